// File: rtl/word_packer.sv
// word_packer: serial-to-parallel packer.
// Collects LANES beats of DIN_W bits into one DIN_W*LANES-bit word held in a
// registered output slot with its own valid/ready handshake. Lane order
// (MSB-first / LSB-first) is latched per word; a partial word can be flushed.
//
// Optional feature: define WORD_PACKER_PARITY_EN to add the dout_par output
// (even parity of the word loaded into dout).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   din, din_valid        input beat and its valid
//   din_ready             beat accepted when din_valid && din_ready (combinational)
//   msb_first             lane order for the word being started
//   flush                 request to emit the current partial word
//   dout, dout_valid      registered assembled word and its valid
//   dout_ready            consumer accepts the word
//   fill_count            beats currently held in the assembly register
//   dout_par              parity of dout (WORD_PACKER_PARITY_EN only)
module word_packer #(
  parameter  int unsigned DIN_W  = 4,
  parameter  int unsigned LANES  = 2,
  localparam int unsigned DOUT_W = DIN_W * LANES,
  localparam int unsigned CW     = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              msb_first,
  input  logic              flush,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CW-1:0]     fill_count
`ifdef WORD_PACKER_PARITY_EN
  ,
  output logic              dout_par
`endif
);

  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  logic [DOUT_W-1:0] asm_q, asm_wr, asm_d;
  logic [DOUT_W-1:0] dout_d;
  logic [CW-1:0]     fill_d, lane;
  logic [CW:0]       cnt_post;
  logic              order_q, order_d, order_cur;
  logic              pend_q, pend_d;
  logic              valid_d;
  logic              slot_free, accept, complete, flush_req, do_flush, emit;
`ifdef WORD_PACKER_PARITY_EN
  logic              par_d;
`endif

  // Next-state and handshake logic
  always_comb begin
    slot_free = !dout_valid || dout_ready;
    din_ready = ((fill_count != LAST) && !pend_q) || slot_free;
    accept    = din_valid && din_ready;

    // Order is taken live on the first beat of a word, latched afterwards
    order_cur = (fill_count == '0) ? msb_first : order_q;
    lane      = order_cur ? (LAST - fill_count) : fill_count;

    asm_wr = asm_q;
    for (int k = 0; k < int'(LANES); k++) begin
      if (accept && (lane == CW'(k))) begin
        asm_wr[k*DIN_W +: DIN_W] = din;
      end
    end

    cnt_post  = (CW+1)'(fill_count) + (CW+1)'(accept);
    complete  = accept && (fill_count == LAST);
    // A pending flush behaves like a fresh request until the slot frees
    flush_req = flush || pend_q;
    do_flush  = flush_req && (cnt_post != '0) && slot_free && !complete;
    emit      = complete || do_flush;

    asm_d   = asm_wr;
    fill_d  = accept ? (fill_count + CW'(1)) : fill_count;
    order_d = (accept && (fill_count == '0)) ? msb_first : order_q;
    dout_d  = dout;
    valid_d = dout_valid && !dout_ready;
    pend_d  = flush_req && (cnt_post != '0) && !complete;
`ifdef WORD_PACKER_PARITY_EN
    par_d   = dout_par;
`endif

    if (emit) begin
      dout_d  = asm_wr;
      valid_d = 1'b1;
      fill_d  = '0;
      asm_d   = '0;
      pend_d  = 1'b0;
`ifdef WORD_PACKER_PARITY_EN
      par_d   = ^asm_wr;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      fill_count <= '0;
      order_q    <= 1'b0;
      pend_q     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
`ifdef WORD_PACKER_PARITY_EN
      dout_par   <= 1'b0;
`endif
    end else begin
      asm_q      <= asm_d;
      fill_count <= fill_d;
      order_q    <= order_d;
      pend_q     <= pend_d;
      dout       <= dout_d;
      dout_valid <= valid_d;
`ifdef WORD_PACKER_PARITY_EN
      dout_par   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Testbench for word_packer: two instances (4x2 and 4x4), directed beats,
// expected words queued at issue time and checked by per-instance monitors.
module tb_word_packer;

  logic clk, rst_n;

  logic [3:0]  a_din;
  logic        a_v, a_msb, a_flush, a_rdy, a_dr, a_dv;
  logic [7:0]  a_dout;
  logic [0:0]  a_fc;
  logic [3:0]  b_din;
  logic        b_v, b_msb, b_flush, b_rdy, b_dr, b_dv;
  logic [15:0] b_dout;
  logic [1:0]  b_fc;
`ifdef WORD_PACKER_PARITY_EN
  logic        a_par, b_par;
`endif

  logic [7:0]  qa[$];
  logic [15:0] qb[$];
  int checks = 0;
  int errors = 0;

  word_packer #(.DIN_W(4), .LANES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_v), .din_ready(a_dr),
    .msb_first(a_msb), .flush(a_flush), .dout(a_dout), .dout_valid(a_dv),
    .dout_ready(a_rdy), .fill_count(a_fc)
`ifdef WORD_PACKER_PARITY_EN
    , .dout_par(a_par)
`endif
  );

  word_packer #(.DIN_W(4), .LANES(4)) u_b (
    .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_v), .din_ready(b_dr),
    .msb_first(b_msb), .flush(b_flush), .dout(b_dout), .dout_valid(b_dv),
    .dout_ready(b_rdy), .fill_count(b_fc)
`ifdef WORD_PACKER_PARITY_EN
    , .dout_par(b_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [3:0] d, input logic m, input logic f);
    a_v = v; a_din = d; a_msb = m; a_flush = f;
  endtask

  task automatic set_b(input logic v, input logic [3:0] d, input logic m, input logic f);
    b_v = v; b_din = d; b_msb = m; b_flush = f;
  endtask

  // Output monitors: pop and compare on every completed output handshake
  always @(negedge clk) begin
    if (rst_n && a_dv && a_rdy) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got word %0h expected none", a_dout);
      end else begin
        logic [7:0] e;
        e = qa.pop_front();
        chk("a_dout", 32'(a_dout), 32'(e));
`ifdef WORD_PACKER_PARITY_EN
        chk("a_par", 32'(a_par), 32'(^e));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_dv && b_rdy) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got word %0h expected none", b_dout);
      end else begin
        logic [15:0] e;
        e = qb.pop_front();
        chk("b_dout", 32'(b_dout), 32'(e));
`ifdef WORD_PACKER_PARITY_EN
        chk("b_par", 32'(b_par), 32'(^e));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_a(0, 4'h0, 0, 0); a_rdy = 1'b1;
    set_b(0, 4'h0, 0, 0); b_rdy = 1'b1;
    #2;
    chk("rst_dout", 32'(a_dout), 32'h0);
    chk("rst_dv", 32'(a_dv), 32'h0);
    chk("rst_fc", 32'(a_fc), 32'h0);
    chk("rst_dr", 32'(a_dr), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // MSB-first A,5 -> A5
    set_a(1, 4'hA, 1, 0); tick();
    chk("a_fc_1", 32'(a_fc), 32'h1);
    set_a(1, 4'h5, 1, 0); qa.push_back(8'hA5); tick();
    chk("a_fc_0", 32'(a_fc), 32'h0);
    chk("a_dv_1", 32'(a_dv), 32'h1);
    set_a(0, 4'h0, 1, 0); tick();
    chk("a_dv_clr", 32'(a_dv), 32'h0);

    // LSB-first, order change mid-word ignored -> 5A; then MSB A,4 -> A4
    set_a(1, 4'hA, 0, 0); tick();
    set_a(1, 4'h5, 1, 0); qa.push_back(8'h5A); tick();
    chk("a_dv_5a", 32'(a_dv), 32'h1);
    set_a(1, 4'hA, 1, 0); tick();
    set_a(1, 4'h4, 1, 0); qa.push_back(8'hA4); tick();
    set_a(0, 4'h0, 1, 0); tick();
    chk("a_dv_a4", 32'(a_dv), 32'h0);

    // Backpressure: A5 held, beat 1 accepted, beat 2 stalled
    a_rdy = 1'b0;
    set_a(1, 4'hA, 1, 0); tick();
    set_a(1, 4'h5, 1, 0); qa.push_back(8'hA5); tick();
    set_a(1, 4'h1, 1, 0); #1;
    chk("a_dr_fc0", 32'(a_dr), 32'h1);
    tick();
    chk("a_fc_stall", 32'(a_fc), 32'h1);
    set_a(1, 4'h2, 1, 0); #1;
    chk("a_dr_stall", 32'(a_dr), 32'h0);
    tick();
    chk("a_fc_hold", 32'(a_fc), 32'h1);
    chk("a_dout_hold", 32'(a_dout), 32'hA5);
    chk("a_dv_hold", 32'(a_dv), 32'h1);
    tick();
    chk("a_dout_hold2", 32'(a_dout), 32'hA5);
    a_rdy = 1'b1; qa.push_back(8'h12); #1;
    chk("a_dr_drain", 32'(a_dr), 32'h1);
    tick();
    chk("a_dout_12", 32'(a_dout), 32'h12);
    chk("a_fc_12", 32'(a_fc), 32'h0);
    set_a(0, 4'h0, 1, 0); tick();
    chk("a_dv_12clr", 32'(a_dv), 32'h0);

    // Flush of a single LSB beat -> 01; empty flush does nothing
    set_a(1, 4'h1, 0, 0); tick();
    set_a(0, 4'h0, 0, 1); qa.push_back(8'h01); tick();
    chk("a_fc_flush", 32'(a_fc), 32'h0);
    chk("a_dv_flush", 32'(a_dv), 32'h1);
    set_a(0, 4'h0, 0, 1); tick();
    chk("a_dv_noflush", 32'(a_dv), 32'h0);
    set_a(0, 4'h0, 0, 0);

    // Asynchronous reset mid-word discards the partial beat
    set_a(1, 4'h3, 1, 0); tick();
    set_a(0, 4'h0, 1, 0);
    chk("a_fc_pre_rst", 32'(a_fc), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(a_dout), 32'h0);
    chk("arst_dv", 32'(a_dv), 32'h0);
    chk("arst_fc", 32'(a_fc), 32'h0);
    chk("arst_dr", 32'(a_dr), 32'h1);
    #2 rst_n = 1'b1;
    tick();
    set_a(1, 4'h4, 1, 0); tick();
    set_a(1, 4'h5, 1, 0); qa.push_back(8'h45); tick();
    set_a(0, 4'h0, 1, 0); tick();

    // 4-lane: LSB 1,2 then flush -> 0021; empty flush
    set_b(1, 4'h1, 0, 0); tick();
    set_b(1, 4'h2, 0, 0); tick();
    set_b(0, 4'h0, 0, 1); qb.push_back(16'h0021); tick();
    chk("b_fc_flush", 32'(b_fc), 32'h0);
    chk("b_dv_flush", 32'(b_dv), 32'h1);
    set_b(0, 4'h0, 0, 1); tick();
    chk("b_dv_noflush", 32'(b_dv), 32'h0);

    // Pending flush while output slot is blocked
    b_rdy = 1'b0;
    set_b(1, 4'h1, 0, 0); tick();
    set_b(1, 4'h2, 0, 0); tick();
    set_b(1, 4'h3, 0, 0); tick();
    set_b(1, 4'h4, 0, 0); qb.push_back(16'h4321); tick();
    chk("b_dv_4321", 32'(b_dv), 32'h1);
    set_b(1, 4'h9, 0, 0); tick();
    chk("b_fc_9", 32'(b_fc), 32'h1);
    set_b(0, 4'h0, 0, 1); tick();
    chk("b_fc_pend", 32'(b_fc), 32'h1);
    set_b(0, 4'h0, 0, 0); #1;
    chk("b_dr_pend", 32'(b_dr), 32'h0);
    tick();
    chk("b_dout_hold", 32'(b_dout), 32'h4321);
    b_rdy = 1'b1; qb.push_back(16'h0009); tick();
    chk("b_dout_0009", 32'(b_dout), 32'h0009);
    chk("b_fc_0009", 32'(b_fc), 32'h0);
    b_rdy = 1'b0; #1;
    chk("b_dr_after_pend", 32'(b_dr), 32'h1);
    b_rdy = 1'b1; tick();

    // Completing beat with simultaneous flush: one word only
    set_b(1, 4'h5, 0, 0); tick();
    set_b(1, 4'h6, 0, 0); tick();
    set_b(1, 4'h7, 0, 0); tick();
    set_b(1, 4'h8, 0, 1); qb.push_back(16'h8765); tick();
    chk("b_dv_8765", 32'(b_dv), 32'h1);
    chk("b_fc_8765", 32'(b_fc), 32'h0);
    set_b(0, 4'h0, 0, 0); tick();
    chk("b_dv_noextra", 32'(b_dv), 32'h0);
    tick();
    chk("b_dv_noextra2", 32'(b_dv), 32'h0);

    // 4-lane MSB-first -> 1234
    set_b(1, 4'h1, 1, 0); tick();
    set_b(1, 4'h2, 0, 0); tick();
    set_b(1, 4'h3, 0, 0); tick();
    set_b(1, 4'h4, 0, 0); qb.push_back(16'h1234); tick();
    set_b(0, 4'h0, 0, 0); tick(); tick();

    chk("qa_empty", 32'(qa.size()), 32'h0);
    chk("qb_empty", 32'(qb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
